flash_page_packer: RTL and testbench
====================================

# flash_page_packer

Upstream feeder for the Ethernet TX FIFO in the flash-test datapath. Runs in the clk_25M domain. Requests fixed-size page reads from the flash reader, packs the returned byte stream into 32-bit big-endian words, and writes them into the async FIFO. The GMII side of that FIFO starts a UDP frame whenever 256 words are buffered. A page request is issued only when the FIFO has room for the whole page, so the flash reader is never stalled.

## Interface
- PAGE_BYTES, 256, bytes per flash page read; multiple of 4
- ADDR_W, 24, flash byte-address width
- START_ADDR, 0, first page address of a pass
- LAST_ADDR, 24'hFFFF00, last page address of a pass; wrap follows it
- FIFO_DEPTH, 512, FIFO depth in 32-bit words
- FREE_MARGIN, 8, extra free words required beyond one page; covers count latency

- clk_25M  in  1  write-side clock
- I_rst_n  in  1  asynchronous, active-low reset
- fifo_rdy  in  1  synchronized FIFO-reset release, clk_25M domain; high = FIFO usable
- run  in  1  level enable for streaming
- page_req  out  1  page read request, held until page_ack
- page_addr  out  ADDR_W  start byte address of the requested page, stable while page_req
- page_ack  in  1  one-cycle accept from the flash reader
- byte_valid  in  1  qualifies byte_data
- byte_data  in  8  flash read byte
- page_done  in  1  one-cycle end-of-page pulse; may coincide with the last byte_valid
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  32  packed word
- fifo_full  in  1  FIFO full flag
- wr_data_count  in  9  FIFO write-side word count
- wrap_pulse  out  1  one-cycle pulse when a full address pass completes
- len_err  out  1  sticky: page_done arrived with byte count ≠ PAGE_BYTES
- ovf_err  out  1  sticky: a word was ready while fifo_full

## Operation
- States: IDLE, WAIT_SPACE, REQ, STREAM, NEXT.
- IDLE: if fifo_rdy && run, go to WAIT_SPACE.
- WAIT_SPACE:
  - if !run, go to IDLE.
  - else if wr_data_count ≤ FIFO_DEPTH − PAGE_BYTES/4 − FREE_MARGIN (440 by default) and !fifo_full, go to REQ.
- REQ: page_req=1, page_addr=cur_addr. On page_ack, clear byte_cnt and go to STREAM.
- STREAM:
  - Each byte_valid shifts byte_data into the pack register. The first byte of a word lands in [31:24], the fourth in [7:0].
  - byte_cnt increments per byte_valid. On every 4th byte the word is written.
  - On page_done, go to NEXT. If the final byte_cnt (including a coincident byte) ≠ PAGE_BYTES, set len_err and discard any partial word.
  - Bytes beyond PAGE_BYTES are ignored and also set len_err.
- NEXT:
  - If cur_addr == LAST_ADDR, set cur_addr=START_ADDR and pulse wrap_pulse. Otherwise cur_addr += PAGE_BYTES, in ADDR_W-bit arithmetic.
  - Go to WAIT_SPACE.
- run deassertion is sampled only in WAIT_SPACE. A requested page always completes.
- fifo_full at write time: the word is dropped (fifo_wr_en stays 0) and ovf_err is set. Streaming continues.
- fifo_rdy low in any state: synchronous abort to IDLE on the next edge.
  - page_req, fifo_wr_en, byte_cnt and the pack register clear; cur_addr returns to START_ADDR.
  - Error flags are held.
- Error flags clear only on I_rst_n.

## Timing
- Reset values:
  - page_req=0, page_addr=START_ADDR, fifo_wr_en=0, fifo_din=0.
  - wrap_pulse=0, len_err=0, ovf_err=0.
  - State IDLE, cur_addr=START_ADDR.
- Write latency: fifo_wr_en and fifo_din are registered and assert the cycle after the edge that captures the 4th byte. fifo_wr_en is high for exactly one cycle per word.
- page_req rises one cycle after entering REQ and falls on the edge after page_ack is sampled.
- Minimum gap between page_done and the next page_req is 3 cycles (NEXT, WAIT_SPACE, REQ).
- Back-to-back byte_valid at full clock rate is supported. This gives at most one write per 4 cycles.
- A page_done coincident with the 4th byte of the last word still produces that write.
- The page_ack→STREAM transition is registered. A byte_valid in the same cycle as page_ack is illegal and ignored.

## Structure
- A shared package holds the state encoding typedef and the derived constants: WORDS_PER_PAGE = PAGE_BYTES/4 and FREE_THRESH = FIFO_DEPTH − WORDS_PER_PAGE − FREE_MARGIN.
- One sub-module, byte_packer_32: the shift register, 2-bit lane counter, registered word output and write strobe, with a clear input.
- The top level holds the FSM, address counter, byte counter and error flags.

## Test plan
- Reset release, fifo_rdy=1, run=1, wr_data_count=0 → page_req with page_addr=0x000000. After page_ack and 256 bytes 0x00..0xFF: 64 writes, first fifo_din=0x00010203, last 0xFCFDFEFF, then the next page_req at 0x000100.
- wr_data_count=441 → no page_req. Drop it to 440 → page_req 3 cycles later.
- page_done after 254 bytes → 63 writes, len_err=1, next page_addr still advances by 0x100.
- fifo_full=1 during the 10th word → that write suppressed, ovf_err=1, remaining 54 words written.
- LAST_ADDR=0x000100, START_ADDR=0: two pages → wrap_pulse one cycle after the second page_done, third page_addr=0x000000.
- fifo_rdy dropped mid-STREAM → next cycle IDLE, page_req=0, fifo_wr_en=0. On re-enable, page_addr=START_ADDR; error flags unchanged.

Source files
------------

// File: rtl/flash_page_packer_pkg.sv
// flash_page_packer_pkg
//   Shared definitions for the flash page packer: FSM state encoding and
//   helpers that derive the page/FIFO constants from the top-level parameters.
//   No ports.
package flash_page_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_SPACE = 3'd1,
        ST_REQ        = 3'd2,
        ST_STREAM     = 3'd3,
        ST_NEXT       = 3'd4
    } state_t;

    // 32-bit words produced by one page.
    function automatic int words_per_page(input int page_bytes);
        return page_bytes / 4;
    endfunction

    // Highest FIFO word count at which a whole page (plus margin) still fits.
    function automatic int free_thresh(input int fifo_depth, input int words, input int margin);
        return fifo_depth - words - margin;
    endfunction

endpackage

// File: rtl/flash_page_packer_byte_packer_32.sv
// byte_packer_32
//   Packs a byte stream into 32-bit big-endian words. The first byte of a word
//   lands in [31:24], the fourth in [7:0]. The completed word and its write
//   strobe are registered, so they appear the cycle after the 4th byte.
// Ports:
//   clk_25M  in   clock
//   I_rst_n  in   asynchronous active-low reset
//   push     in   accept din into the shift register
//   din      in   byte to pack
//   clr      in   discard the partial word (lane counter and shift register)
//   block    in   downstream full: a completed word is dropped instead of written
//   word     out  last written word
//   wr_en    out  one-cycle strobe per written word
//   drop     out  combinational: a word completed this cycle but was blocked
module byte_packer_32 (
    input  logic        clk_25M,
    input  logic        I_rst_n,
    input  logic        push,
    input  logic [7:0]  din,
    input  logic        clr,
    input  logic        block,
    output logic [31:0] word,
    output logic        wr_en,
    output logic        drop
);

    logic [23:0] shift;
    logic [1:0]  lane;
    logic        word_done;

    assign word_done = push && (lane == 2'd3);
    assign drop      = word_done && block;

    always_ff @(posedge clk_25M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            shift <= '0;
            lane  <= '0;
            word  <= '0;
            wr_en <= 1'b0;
        end else begin
            wr_en <= word_done && !block;
            if (word_done && !block) begin
                word <= {shift, din};
            end
            // A word completing in the same cycle as clr is still written;
            // clr only throws away what is left in the shift register.
            if (clr) begin
                shift <= '0;
                lane  <= '0;
            end else if (push) begin
                shift <= {shift[15:0], din};
                lane  <= lane + 2'd1;
            end
        end
    end

endmodule

// File: rtl/flash_page_packer.sv
// flash_page_packer
//   Requests fixed-size page reads from the flash reader whenever the TX FIFO
//   has room for a whole page, packs the returned bytes into 32-bit big-endian
//   words and writes them into the FIFO. Walks page addresses from START_ADDR
//   to LAST_ADDR and wraps.
// Ports:
//   clk_25M        in   write-side clock
//   I_rst_n        in   asynchronous active-low reset
//   fifo_rdy       in   FIFO usable; low aborts to IDLE
//   run            in   streaming enable (sampled between pages)
//   page_req       out  page read request, held until page_ack
//   page_addr      out  start byte address of the requested page
//   page_ack       in   one-cycle accept from the flash reader
//   byte_valid     in   qualifies byte_data
//   byte_data      in   flash read byte
//   page_done      in   end-of-page pulse
//   fifo_wr_en     out  FIFO write strobe
//   fifo_din       out  packed word
//   fifo_full      in   FIFO full flag
//   wr_data_count  in   FIFO write-side word count
//   wrap_pulse     out  one-cycle pulse when the address pass completes
//   len_err        out  sticky: page length mismatch
//   ovf_err        out  sticky: word dropped on fifo_full
module flash_page_packer
    import flash_page_packer_pkg::*;
#(
    parameter int                PAGE_BYTES  = 256,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(24'hFFFF00),
    parameter int                FIFO_DEPTH  = 512,
    parameter int                FREE_MARGIN = 8
) (
    input  logic              clk_25M,
    input  logic              I_rst_n,
    input  logic              fifo_rdy,
    input  logic              run,
    output logic              page_req,
    output logic [ADDR_W-1:0] page_addr,
    input  logic              page_ack,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              page_done,
    output logic              fifo_wr_en,
    output logic [31:0]       fifo_din,
    input  logic              fifo_full,
    input  logic [8:0]        wr_data_count,
    output logic              wrap_pulse,
    output logic              len_err,
    output logic              ovf_err
);

    localparam int WORDS_PER_PAGE = words_per_page(PAGE_BYTES);
    localparam int FREE_THRESH    = free_thresh(FIFO_DEPTH, WORDS_PER_PAGE, FREE_MARGIN);
    localparam int CNT_W          = $clog2(PAGE_BYTES + 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  cnt_final;
    logic              space_ok;
    logic              at_last;

    // Decoded per-cycle actions from the output process
    logic              req_hold;
    logic              ack_take;
    logic              take_byte;
    logic              extra_byte;
    logic              done_evt;
    logic              advance;
    logic              pk_clr;
    logic              pk_drop;

    assign space_ok  = (32'(wr_data_count) <= 32'(FREE_THRESH)) && !fifo_full;
    assign at_last   = (cur_addr == LAST_ADDR);
    assign cnt_final = byte_cnt + CNT_W'(take_byte);
    assign page_addr = cur_addr;

    // State register
    always_ff @(posedge clk_25M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; fifo_rdy low overrides everything
    always_comb begin
        state_nxt = state;
        if (!fifo_rdy) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state_nxt = ST_WAIT_SPACE;
                end
                ST_WAIT_SPACE: begin
                    if (!run)          state_nxt = ST_IDLE;
                    else if (space_ok) state_nxt = ST_REQ;
                end
                ST_REQ: begin
                    if (page_ack) state_nxt = ST_STREAM;
                end
                ST_STREAM: begin
                    if (page_done) state_nxt = ST_NEXT;
                end
                ST_NEXT: begin
                    state_nxt = ST_WAIT_SPACE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output / action decode
    always_comb begin
        req_hold   = 1'b0;
        ack_take   = 1'b0;
        take_byte  = 1'b0;
        extra_byte = 1'b0;
        done_evt   = 1'b0;
        advance    = 1'b0;
        if (fifo_rdy) begin
            case (state)
                ST_REQ: begin
                    req_hold = !page_ack;
                    ack_take = page_ack;
                end
                ST_STREAM: begin
                    take_byte  = byte_valid && (byte_cnt < CNT_W'(PAGE_BYTES));
                    extra_byte = byte_valid && (byte_cnt >= CNT_W'(PAGE_BYTES));
                    done_evt   = page_done;
                end
                ST_NEXT: begin
                    advance = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wrap_pulse = (state == ST_NEXT) && at_last;

    // The packer is cleared at the start and end of every page and on abort,
    // so a short page never leaks bytes into the next one.
    assign pk_clr = !fifo_rdy || ack_take || done_evt;

    always_ff @(posedge clk_25M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cur_addr <= START_ADDR;
            byte_cnt <= '0;
            page_req <= 1'b0;
            len_err  <= 1'b0;
            ovf_err  <= 1'b0;
        end else if (!fifo_rdy) begin
            cur_addr <= START_ADDR;
            byte_cnt <= '0;
            page_req <= 1'b0;
        end else begin
            page_req <= req_hold;
            if (ack_take) begin
                byte_cnt <= '0;
            end else if (take_byte) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (extra_byte || (done_evt && (cnt_final != CNT_W'(PAGE_BYTES)))) begin
                len_err <= 1'b1;
            end
            if (pk_drop) begin
                ovf_err <= 1'b1;
            end
            if (advance) begin
                cur_addr <= at_last ? START_ADDR : cur_addr + ADDR_W'(PAGE_BYTES);
            end
        end
    end

    byte_packer_32 u_packer (
        .clk_25M (clk_25M),
        .I_rst_n (I_rst_n),
        .push    (take_byte),
        .din     (byte_data),
        .clr     (pk_clr),
        .block   (fifo_full),
        .word    (fifo_din),
        .wr_en   (fifo_wr_en),
        .drop    (pk_drop)
    );

endmodule

// File: tb/tb_flash_page_packer.sv
// tb_flash_page_packer
//   Directed bench for flash_page_packer with LAST_ADDR = 0x000100 so the
//   address wrap is reached after two pages.
module tb_flash_page_packer;

    logic        clk_25M = 1'b0;
    logic        I_rst_n;
    logic        fifo_rdy;
    logic        run;
    logic        page_req;
    logic [23:0] page_addr;
    logic        page_ack;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        page_done;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        fifo_full;
    logic [8:0]  wr_data_count;
    logic        wrap_pulse;
    logic        len_err;
    logic        ovf_err;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] wq[$];

    always #20 clk_25M = ~clk_25M;

    flash_page_packer #(
        .PAGE_BYTES  (256),
        .ADDR_W      (24),
        .START_ADDR  (24'h000000),
        .LAST_ADDR   (24'h000100),
        .FIFO_DEPTH  (512),
        .FREE_MARGIN (8)
    ) dut (
        .clk_25M       (clk_25M),
        .I_rst_n       (I_rst_n),
        .fifo_rdy      (fifo_rdy),
        .run           (run),
        .page_req      (page_req),
        .page_addr     (page_addr),
        .page_ack      (page_ack),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .page_done     (page_done),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_din      (fifo_din),
        .fifo_full     (fifo_full),
        .wr_data_count (wr_data_count),
        .wrap_pulse    (wrap_pulse),
        .len_err       (len_err),
        .ovf_err       (ovf_err)
    );

    // Collect every FIFO write
    always @(posedge clk_25M) begin
        if (fifo_wr_en === 1'b1) wq.push_back(fifo_din);
    end

    task automatic step();
        @(posedge clk_25M);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int idx);
        if (idx < wq.size()) return wq[idx];
        return 32'hDEADBEEF;
    endfunction

    // Wait (bounded) for page_req, check its address, acknowledge it.
    task automatic take_req(input logic [23:0] addr, input string tag);
        int n = 0;
        while (page_req !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk(32'(page_req), 32'd1, {tag, "_req"});
        chk(32'(page_addr), 32'(addr), {tag, "_addr"});
        page_ack = 1'b1;
        step();
        page_ack = 1'b0;
        chk(32'(page_req), 32'd0, {tag, "_req_drop"});
    endtask

    // Stream n bytes 0,1,2,..; page_done on the last; fifo_full on byte full_idx.
    task automatic send_page(input int n, input int full_idx);
        wq.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] iv;
            iv         = 32'(i);
            byte_valid = 1'b1;
            byte_data  = iv[7:0];
            page_done  = (i == n - 1);
            fifo_full  = (i == full_idx);
            step();
        end
        byte_valid = 1'b0;
        page_done  = 1'b0;
        fifo_full  = 1'b0;
    endtask

    initial begin
        I_rst_n       = 1'b0;
        fifo_rdy      = 1'b0;
        run           = 1'b0;
        page_ack      = 1'b0;
        byte_valid    = 1'b0;
        byte_data     = 8'h00;
        page_done     = 1'b0;
        fifo_full     = 1'b0;
        wr_data_count = 9'd0;
        step();
        step();

        // Reset state
        chk(32'(page_req),   32'd0, "rst_page_req");
        chk(32'(page_addr),  32'd0, "rst_page_addr");
        chk(32'(fifo_wr_en), 32'd0, "rst_wr_en");
        chk(fifo_din,        32'd0, "rst_din");
        chk(32'(wrap_pulse), 32'd0, "rst_wrap");
        chk(32'(len_err),    32'd0, "rst_len_err");
        chk(32'(ovf_err),    32'd0, "rst_ovf_err");

        I_rst_n  = 1'b1;
        fifo_rdy = 1'b1;
        run      = 1'b1;

        // Full page at 0x000000
        take_req(24'h000000, "p0");
        send_page(256, -1);
        chk(32'(wrap_pulse), 32'd0, "p0_no_wrap");
        wr_data_count = 9'd441;
        step();
        chk(32'(wq.size()), 32'd64, "p0_words");
        chk(word_at(0),  32'h00010203, "p0_first");
        chk(word_at(10), 32'h28292A2B, "p0_mid");
        chk(word_at(63), 32'hFCFDFEFF, "p0_last");
        chk(32'(len_err), 32'd0, "p0_len_err");
        chk(32'(ovf_err), 32'd0, "p0_ovf_err");

        // 441 buffered words: no request
        for (int i = 0; i < 10; i++) step();
        chk(32'(page_req), 32'd0, "cnt441_no_req");
        wr_data_count = 9'd440;
        step();
        chk(32'(page_req), 32'd0, "cnt440_not_yet");
        step();
        step();
        chk(32'(page_req), 32'd1, "cnt440_req");
        wr_data_count = 9'd0;

        // Page at 0x000100 with fifo_full on the 10th word; this is LAST_ADDR
        take_req(24'h000100, "p1");
        send_page(256, 39);
        chk(32'(wrap_pulse), 32'd1, "p1_wrap");
        step();
        chk(32'(wrap_pulse), 32'd0, "p1_wrap_end");
        chk(32'(wq.size()), 32'd63, "p1_words");
        chk(word_at(8),  32'h20212223, "p1_before_drop");
        chk(word_at(9),  32'h28292A2B, "p1_after_drop");
        chk(32'(ovf_err), 32'd1, "p1_ovf_err");
        chk(32'(len_err), 32'd0, "p1_len_err");

        // Wrapped back to 0x000000; short page of 254 bytes
        take_req(24'h000000, "p2");
        send_page(254, -1);
        step();
        chk(32'(wq.size()), 32'd63, "p2_words");
        chk(word_at(62), 32'hF8F9FAFB, "p2_last");
        chk(32'(len_err), 32'd1, "p2_len_err");

        // Address still advances; abort mid-stream on the 4th byte of word 5
        take_req(24'h000100, "p3");
        wq.delete();
        for (int i = 0; i < 23; i++) begin
            logic [31:0] iv;
            iv         = 32'(i);
            byte_valid = 1'b1;
            byte_data  = iv[7:0];
            step();
        end
        byte_data = 8'd23;
        fifo_rdy  = 1'b0;
        step();
        byte_valid = 1'b0;
        chk(32'(page_req),   32'd0, "abort_req");
        chk(32'(fifo_wr_en), 32'd0, "abort_wr_en");
        step();
        chk(32'(wq.size()), 32'd5, "abort_words");
        chk(32'(len_err), 32'd1, "abort_len_err_held");
        chk(32'(ovf_err), 32'd1, "abort_ovf_err_held");
        fifo_rdy = 1'b1;

        // Re-enabled: restarts at START_ADDR with a clean pack register
        take_req(24'h000000, "p4");
        send_page(256, -1);
        step();
        chk(32'(wq.size()), 32'd64, "p4_words");
        chk(word_at(0),  32'h00010203, "p4_first");
        chk(word_at(63), 32'hFCFDFEFF, "p4_last");
        chk(32'(len_err), 32'd1, "p4_len_err_held");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
